// File: rtl/gf_poly_mul_seq.sv
// Sequential GF(2^SIZE) polynomial multiplier: one row of partial products per cycle,
// N+1 field multipliers in parallel, valid/ready handshake on both sides.
module gf_poly_mul_seq #(
  parameter int SIZE = 8,
  parameter int PRIM = 285,
  parameter int N    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [(N+1)*SIZE-1:0]         flat_p,
  input  logic [(N+1)*SIZE-1:0]         flat_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [(2*N+1)*SIZE-1:0]       flat_z,
  output logic [$clog2(2*N+1)-1:0]      z_deg,
  output logic                          z_zero
);

  localparam int NC = N + 1;
  localparam int NZ = 2 * N + 1;
  localparam int RW = (N >= 1) ? $clog2(N + 1) : 1;
  localparam int DW = $clog2(2 * N + 1);

  // Reduction constant: PRIM without its implicit x^SIZE term.
  localparam logic [SIZE-1:0] POLY = SIZE'(PRIM);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]      state;
  logic [RW-1:0]   row;
  logic [SIZE-1:0] p_reg   [NC];
  logic [SIZE-1:0] q_reg   [NC];
  logic [SIZE-1:0] acc     [NZ];
  logic [SIZE-1:0] acc_nxt [NZ];
  logic [SIZE-1:0] prod    [NC];
  logic [SIZE-1:0] p_row;

  // Shift-and-add field multiply; the shifted multiplicand is reduced every step
  // so it never exceeds SIZE bits.
  function automatic logic [SIZE-1:0] gf_mul(input logic [SIZE-1:0] a,
                                             input logic [SIZE-1:0] b);
    logic [SIZE-1:0] res;
    logic [SIZE-1:0] sh;
    res = '0;
    sh  = a;
    for (int i = 0; i < SIZE; i++) begin
      if (b[i]) res = res ^ sh;
      sh = {sh[SIZE-2:0], 1'b0} ^ (sh[SIZE-1] ? POLY : '0);
    end
    return res;
  endfunction

  assign p_row = p_reg[row];

  always_comb begin
    for (int j = 0; j < NC; j++) begin
      prod[j] = gf_mul(p_row, q_reg[j]);
    end
  end

  always_comb begin
    for (int k = 0; k < NZ; k++) begin
      acc_nxt[k] = acc[k];
    end
    for (int j = 0; j < NC; j++) begin
      if (int'(row) + j < NZ) begin
        acc_nxt[int'(row) + j] = acc_nxt[int'(row) + j] ^ prod[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      row   <= '0;
      for (int k = 0; k < NC; k++) begin
        p_reg[k] <= '0;
        q_reg[k] <= '0;
      end
      for (int k = 0; k < NZ; k++) begin
        acc[k] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < NC; k++) begin
              p_reg[k] <= flat_p[k*SIZE +: SIZE];
              q_reg[k] <= flat_q[k*SIZE +: SIZE];
            end
            for (int k = 0; k < NZ; k++) begin
              acc[k] <= '0;
            end
            row   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int k = 0; k < NZ; k++) begin
            acc[k] <= acc_nxt[k];
          end
          row <= row + 1'b1;
          if (row == RW'(N)) state <= DONE;
        end
        DONE: begin
          // Accumulator is frozen here, so the product stays stable until consumed.
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    for (int k = 0; k < NZ; k++) begin
      flat_z[k*SIZE +: SIZE] = acc[k];
    end
  end

  // Ascending scan leaves the highest nonzero index in z_deg.
  always_comb begin
    z_deg  = '0;
    z_zero = 1'b1;
    for (int k = 0; k < NZ; k++) begin
      if (acc[k] != '0) begin
        z_deg  = DW'(k);
        z_zero = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gf_poly_mul_seq.sv
// Bench for gf_poly_mul_seq: directed cases on an N=2 instance, randomized
// transactions on N=2 and N=4 instances against a polynomial reference model.
module tb_gf_poly_mul_seq;

  localparam int PRIM = 285;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        drv_valid;
  logic        drv_ready;
  logic [39:0] drv_p;
  logic [39:0] drv_q;

  logic        in_ready_a, out_valid_a, z_zero_a;
  logic [39:0] flat_z_a;
  logic [2:0]  z_deg_a;
  logic        in_ready_b, out_valid_b, z_zero_b;
  logic [71:0] flat_z_b;
  logic [3:0]  z_deg_b;

  logic        cur_valid, cur_ready, cur_zero;
  logic [71:0] cur_z;
  logic [3:0]  cur_deg;

  int n_cmp = 0;
  int n_bad = 0;

  gf_poly_mul_seq #(.SIZE(8), .PRIM(PRIM), .N(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(drv_valid & ~sel), .in_ready(in_ready_a),
    .flat_p(drv_p[23:0]), .flat_q(drv_q[23:0]),
    .out_valid(out_valid_a), .out_ready(drv_ready & ~sel),
    .flat_z(flat_z_a), .z_deg(z_deg_a), .z_zero(z_zero_a)
  );

  gf_poly_mul_seq #(.SIZE(8), .PRIM(PRIM), .N(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(drv_valid & sel), .in_ready(in_ready_b),
    .flat_p(drv_p), .flat_q(drv_q),
    .out_valid(out_valid_b), .out_ready(drv_ready & sel),
    .flat_z(flat_z_b), .z_deg(z_deg_b), .z_zero(z_zero_b)
  );

  assign cur_valid = sel ? out_valid_b : out_valid_a;
  assign cur_ready = sel ? in_ready_b  : in_ready_a;
  assign cur_zero  = sel ? z_zero_b    : z_zero_a;
  assign cur_z     = sel ? flat_z_b    : {32'h0, flat_z_a};
  assign cur_deg   = sel ? z_deg_b     : {1'b0, z_deg_a};

  // Reference: carry-less product then polynomial long division by PRIM.
  function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] c;
    c = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) c = c ^ ({8'h0, a} << i);
    for (int t = 15; t >= 8; t--) if (c[t]) c = c ^ (16'(PRIM) << (t - 8));
    return c[7:0];
  endfunction

  function automatic void ref_poly(input int n, input logic [39:0] fp, input logic [39:0] fq,
                                   output logic [71:0] fz, output int deg, output logic zero);
    logic [7:0] z [9];
    for (int k = 0; k < 9; k++) z[k] = 8'h0;
    for (int i = 0; i <= n; i++)
      for (int j = 0; j <= n; j++)
        z[i+j] = z[i+j] ^ ref_gmul(fp[i*8 +: 8], fq[j*8 +: 8]);
    fz = 72'h0; deg = 0; zero = 1'b1;
    for (int k = 0; k <= 2*n; k++) begin
      fz[k*8 +: 8] = z[k];
      if (z[k] != 8'h0) begin deg = k; zero = 1'b0; end
    end
  endfunction

  // Offer one operand pair, then count edges until out_valid (bounded).
  task automatic start_txn(input logic [39:0] p, input logic [39:0] q, output int lat);
    @(negedge clk);
    drv_p = p; drv_q = q; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_p = 40'({$urandom, $urandom});
    drv_q = 40'({$urandom, $urandom});
    lat = 0;
    while (!cur_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_txn(input logic random_ready);
    logic r;
    int cyc;
    cyc = 0;
    do begin
      r = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drv_ready = r;
      @(posedge clk); #1;
      cyc++;
    end while (!r && cyc < 40);
    drv_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", cur_ready); end
    n_cmp++; if (cur_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", cur_valid); end
    n_cmp++; if (cur_z !== 72'h0) begin n_bad++; $display("FAIL reset_flat_z: got %h want 0", cur_z); end
    n_cmp++; if (cur_deg !== 4'd0) begin n_bad++; $display("FAIL reset_z_deg: got %0d want 0", cur_deg); end
    n_cmp++; if (cur_zero !== 1'b1) begin n_bad++; $display("FAIL reset_z_zero: got %b want 1", cur_zero); end
  endtask

  task automatic test_directed(input string name, input logic [39:0] p, input logic [39:0] q,
                               input logic [71:0] ez, input logic [3:0] edeg, input logic ezero);
    int lat;
    start_txn(p, q, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
    n_cmp++; if (cur_ready !== 1'b0) begin n_bad++; $display("FAIL %s_in_ready: got %b want 0", name, cur_ready); end
    n_cmp++; if (cur_z !== ez) begin n_bad++; $display("FAIL %s_flat_z: got %h want %h", name, cur_z, ez); end
    n_cmp++; if (cur_deg !== edeg) begin n_bad++; $display("FAIL %s_z_deg: got %0d want %0d", name, cur_deg, edeg); end
    n_cmp++; if (cur_zero !== ezero) begin n_bad++; $display("FAIL %s_z_zero: got %b want %b", name, cur_zero, ezero); end
    finish_txn(1'b0);
    n_cmp++; if (cur_ready !== 1'b1 || cur_valid !== 1'b0) begin
      n_bad++; $display("FAIL %s_release: got rdy=%b vld=%b want rdy=1 vld=0", name, cur_ready, cur_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] p, q;
    logic [71:0] ez, hold;
    int edeg, lat;
    logic ezero;
    p = 40'h0000_A7_31_C5; q = 40'h0000_0F_E2_19;
    ref_poly(2, p, q, ez, edeg, ezero);
    start_txn(p, q, lat);
    hold = cur_z;
    n_cmp++; if (cur_z !== ez) begin n_bad++; $display("FAIL bp_flat_z: got %h want %h", cur_z, ez); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drv_valid = 1'b1; drv_ready = 1'b0;
      drv_p = 40'({$urandom, $urandom}); drv_q = 40'({$urandom, $urandom});
      @(posedge clk); #1;
      n_cmp++; if (cur_z !== hold) begin n_bad++; $display("FAIL bp_hold_z: got %h want %h", cur_z, hold); end
      n_cmp++; if (cur_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", cur_ready); end
      n_cmp++; if (cur_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", cur_valid); end
    end
    // in_valid stays high across the handshake edge; it must not be taken there.
    @(negedge clk);
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0; drv_valid = 1'b0;
    n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL bp_handshake_in_ready: got %b want 1", cur_ready); end
    n_cmp++; if (cur_valid !== 1'b0) begin n_bad++; $display("FAIL bp_handshake_out_valid: got %b want 0", cur_valid); end
  endtask

  task automatic test_reset_busy();
    logic [39:0] p, q;
    logic [71:0] ez;
    int edeg, lat;
    logic ezero;
    @(negedge clk);
    drv_p = 40'h0000_55_66_77; drv_q = 40'h0000_88_99_AA; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (cur_valid !== 1'b0) begin n_bad++; $display("FAIL rb_out_valid: got %b want 0", cur_valid); end
    n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL rb_in_ready: got %b want 1", cur_ready); end
    n_cmp++; if (cur_z !== 72'h0) begin n_bad++; $display("FAIL rb_flat_z: got %h want 0", cur_z); end
    n_cmp++; if (cur_zero !== 1'b1 || cur_deg !== 4'd0) begin
      n_bad++; $display("FAIL rb_flags: got zero=%b deg=%0d want zero=1 deg=0", cur_zero, cur_deg);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (cur_valid !== 1'b0) begin n_bad++; $display("FAIL rb_held_out_valid: got %b want 0", cur_valid); end
    #2 rst_n = 1'b1;
    p = 40'h0000_12_34_56; q = 40'h0000_9A_BC_DE;
    ref_poly(2, p, q, ez, edeg, ezero);
    start_txn(p, q, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rb_after_latency: got %0d want 3", lat); end
    n_cmp++; if (cur_z !== ez) begin n_bad++; $display("FAIL rb_after_flat_z: got %h want %h", cur_z, ez); end
    finish_txn(1'b0);
  endtask

  task automatic test_random(input logic s, input int count);
    int n, lat, edeg;
    logic [39:0] p, q;
    logic [71:0] ez;
    logic ezero;
    sel = s;
    n = s ? 4 : 2;
    for (int t = 0; t < count; t++) begin
      p = 40'h0; q = 40'h0;
      for (int k = 0; k <= n; k++) begin
        p[k*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h0 : 8'($urandom);
        q[k*8 +: 8] = ($urandom_range(0, 2) == 0) ? 8'h0 : 8'($urandom);
      end
      if ($urandom_range(0, 15) == 0) p = 40'h0;
      ref_poly(n, p, q, ez, edeg, ezero);
      start_txn(p, q, lat);
      n_cmp++; if (lat !== n + 1) begin n_bad++; $display("FAIL rnd_latency N=%0d: got %0d want %0d", n, lat, n + 1); end
      n_cmp++; if (cur_z !== ez) begin n_bad++; $display("FAIL rnd_flat_z N=%0d: got %h want %h", n, cur_z, ez); end
      n_cmp++; if (cur_deg !== 4'(edeg)) begin n_bad++; $display("FAIL rnd_z_deg N=%0d: got %0d want %0d", n, cur_deg, edeg); end
      n_cmp++; if (cur_zero !== ezero) begin n_bad++; $display("FAIL rnd_z_zero N=%0d: got %b want %b", n, cur_zero, ezero); end
      finish_txn(1'b1);
      n_cmp++; if (cur_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_release N=%0d: got %b want 1", n, cur_ready); end
    end
    sel = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    drv_valid = 1'b0; drv_ready = 1'b0; drv_p = 40'h0; drv_q = 40'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #2 rst_n = 1'b1;
    test_directed("basic", 40'h0000_00_01_01, 40'h0000_00_01_01, 72'h00_0000_0001_0001 & 72'hFF_FFFF_FFFF, 4'd2, 1'b0);
    test_directed("reduce", 40'h0000_00_00_02, 40'h0000_00_00_80, 72'h1D, 4'd0, 1'b0);
    test_directed("zero", 40'h0000_00_00_00, 40'h0000_FF_13_57, 72'h0, 4'd0, 1'b1);
    test_backpressure();
    test_reset_busy();
    test_random(1'b0, 1000);
    test_random(1'b1, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gf_poly_mul_seq.md
GF_POLY_MUL_SEQ -- requirements
Module: gf_poly_mul_seq

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning symbol width in bits (field GF(2^SIZE)).
REQ-002 SHALL have parameter PRIM, default 285 (0x11D), meaning the primitive polynomial including the x^SIZE term.
REQ-003 SHALL have parameter N, default 2, meaning the operand polynomial degree (N+1 coefficients, N >= 1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-008 SHALL have ports flat_p and flat_q, input, (N+1)*SIZE bits each: coefficient k in bits [(k+1)*SIZE-1 : k*SIZE].
REQ-009 SHALL have port out_valid, output, 1 bit: product available.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts product.
REQ-011 SHALL have port flat_z, output, (2N+1)*SIZE bits: product coefficients, same packing as flat_p.
REQ-012 SHALL have port z_deg, output, $clog2(2N+1) bits: index of highest nonzero coefficient of flat_z.
REQ-013 SHALL have port z_zero, output, 1 bit: asserted when every coefficient of flat_z is zero.

Function
REQ-014 SHALL compute z[k] = XOR over all i+j=k of p[i]*q[j], with * being GF(2^SIZE) multiplication modulo PRIM and addition being bitwise XOR.
REQ-015 SHALL implement states IDLE, BUSY, DONE; IDLE is the reset state.
REQ-016 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-017 SHALL, on an edge with in_valid && in_ready, latch flat_p and flat_q, clear all 2N+1 accumulator coefficients, set row counter to 0, and enter BUSY.
REQ-018 SHALL, in each BUSY cycle with row counter r, XOR p[r]*q[j] into accumulator coefficient r+j for all j in 0..N in parallel (N+1 field multipliers).
REQ-019 SHALL increment the row counter each BUSY cycle and enter DONE on the edge that processes r = N; latency is exactly N+1 edges from the accepting edge to out_valid high.
REQ-020 SHALL hold flat_z, z_deg, z_zero stable throughout DONE regardless of input activity.
REQ-021 SHALL return to IDLE on an edge with out_valid && out_ready; in_ready rises on that edge, and no new operand is accepted on that same edge.
REQ-022 SHALL ignore in_valid, flat_p, flat_q while in BUSY or DONE; latched operands are unaffected.
REQ-023 SHALL report z_deg = 0 and z_zero = 1 when the product is all zero; otherwise z_zero = 0 and z_deg = highest k with z[k] != 0.
REQ-024 SHALL keep out_valid high indefinitely while out_ready is low (no timeout, no drop).

Reset
REQ-025 SHALL, on rst_n low, asynchronously force state IDLE, row counter 0, accumulator and latched operands 0, out_valid 0, in_ready 1, flat_z 0, z_deg 0, z_zero 1.
REQ-026 SHALL abort any BUSY or DONE operation on reset with no output produced; first acceptance is possible on the first edge after rst_n deasserts.

Verification
REQ-027 SHALL cover: p=(1,1,0), q=(1,1,0) (coeffs k=0..2) -> after 3 edges out_valid=1, z=(1,0,1,0,0), z_deg=2, z_zero=0.
REQ-028 SHALL cover: p=(0x02,0,0), q=(0x80,0,0) -> z=(0x1D,0,0,0,0), z_deg=0, z_zero=0 (reduction by PRIM).
REQ-029 SHALL cover: p=(0,0,0), q=(0x57,0x13,0xFF) -> z all zero, z_deg=0, z_zero=1.
REQ-030 SHALL cover: out_ready held low 5 cycles in DONE while in_valid pulses with new operands -> flat_z unchanged, in_ready=0, then one handshake returns to IDLE.
REQ-031 SHALL cover: rst_n pulsed low during BUSY row 1 -> outputs return to reset values immediately, no out_valid; next transaction yields correct product.
REQ-032 SHALL cover: 1000 random operand pairs with random out_ready, compared against a reference model of REQ-014, also run with N=4.
